// File: rtl/ahb_arb_pkg.sv
// Shared types for the multi-master AHB-Lite arbiter: transfer encodings,
// the buffered address-phase entry and the master index type.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // Sized for the largest supported master count so every instance shares it.
  localparam int MAX_MASTERS = 4;
  localparam int MST_IDX_W   = $clog2(MAX_MASTERS);

  typedef logic [MST_IDX_W-1:0] mst_idx_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
  } ahb_addr_entry_t;

  function automatic mst_idx_t next_idx(input mst_idx_t idx, input int n);
    return (int'(idx) + 1 >= n) ? '0 : idx + mst_idx_t'(1);
  endfunction

endpackage

// File: rtl/ahb_arb_rr_picker.sv
// Round-robin picker: first requester at or after the pointer, wrapping.
// Purely combinational; returns a one-hot grant and the winning index.
module ahb_arb_rr_picker
  import ahb_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  input  mst_idx_t     ptr_i,
  output logic [N-1:0] gnt_o,
  output mst_idx_t     idx_o,
  output logic         valid_o
);

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!valid_o && req_i[i] && (((int'(ptr_i) + k) % N) == i)) begin
          valid_o  = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = mst_idx_t'(i);
        end
      end
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB-Lite master port between NUM_MASTERS masters with
// round-robin arbitration and a one-entry address buffer per master.
module ahb_master_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int RESET_PRIO  = 0
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [NUM_MASTERS-1:0][31:0]  HADDR_M,
  input  logic [NUM_MASTERS-1:0][1:0]   HTRANS_M,
  input  logic [NUM_MASTERS-1:0]        HWRITE_M,
  input  logic [NUM_MASTERS-1:0][2:0]   HSIZE_M,
  input  logic [NUM_MASTERS-1:0][31:0]  HWDATA_M,
  output logic [NUM_MASTERS-1:0]        HREADY_M,
  output logic [NUM_MASTERS-1:0]        HRESP_M,
  output logic [31:0]                   HRDATA_M,
  output logic [31:0]                   HADDR,
  output logic [1:0]                    HTRANS,
  output logic                          HWRITE,
  output logic [2:0]                    HSIZE,
  output logic [31:0]                   HWDATA,
  input  logic                          HREADY,
  input  logic                          HRESP,
  input  logic [31:0]                   HRDATA
);

  ahb_addr_entry_t [NUM_MASTERS-1:0] pend_q, pend_d;
  ahb_addr_entry_t [NUM_MASTERS-1:0] live, cand;
  ahb_addr_entry_t                   win_entry;

  logic [NUM_MASTERS-1:0] eff_req, win_gnt;
  mst_idx_t               win_idx, ptr_q, ptr_d, owner_q, owner_d;
  logic                   win_valid, dvalid_q, dvalid_d, issue;

  // A buffered entry always takes precedence over whatever the master drives now.
  always_comb begin
    live    = '0;
    cand    = '0;
    eff_req = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      live[i].valid = (HTRANS_M[i] == HTRANS_NONSEQ) || (HTRANS_M[i] == HTRANS_SEQ);
      live[i].addr  = HADDR_M[i];
      live[i].write = HWRITE_M[i];
      live[i].size  = HSIZE_M[i];
      cand[i]       = pend_q[i].valid ? pend_q[i] : live[i];
      eff_req[i]    = cand[i].valid;
    end
  end

  ahb_arb_rr_picker #(
    .N (NUM_MASTERS)
  ) u_picker (
    .req_i   (eff_req),
    .ptr_i   (ptr_q),
    .gnt_o   (win_gnt),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  always_comb begin
    win_entry = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (win_gnt[i]) win_entry = cand[i];
    end
  end

  assign issue = HREADY && win_valid && !HRESET;

  // Address phase is forced idle while reset is held, even with live requests.
  always_comb begin
    HTRANS = HTRANS_IDLE;
    HADDR  = '0;
    HWRITE = 1'b0;
    HSIZE  = '0;
    if (win_valid && !HRESET) begin
      HTRANS = HTRANS_NONSEQ;
      HADDR  = win_entry.addr;
      HWRITE = win_entry.write;
      HSIZE  = win_entry.size;
    end
  end

  always_comb begin
    HREADY_M = '1;
    HRESP_M  = '0;
    HWDATA   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (dvalid_q && (owner_q == mst_idx_t'(i))) begin
        HREADY_M[i] = HREADY;
        HRESP_M[i]  = HRESP;
        HWDATA      = HWDATA_M[i];
      end else if (pend_q[i].valid) begin
        HREADY_M[i] = 1'b0;
      end
    end
  end

  assign HRDATA_M = HRDATA;

  always_comb begin
    pend_d   = pend_q;
    owner_d  = owner_q;
    dvalid_d = dvalid_q;
    ptr_d    = ptr_q;
    if (issue) begin
      owner_d  = win_idx;
      dvalid_d = 1'b1;
      ptr_d    = next_idx(win_idx, NUM_MASTERS);
    end else if (HREADY) begin
      dvalid_d = 1'b0;
    end
    // A master whose HREADY_M is high sees its transfer accepted, so buffer it
    // unless it is going straight to the bus this cycle.
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (issue && win_gnt[i]) begin
        pend_d[i].valid = 1'b0;
      end else if (HREADY_M[i] && live[i].valid) begin
        pend_d[i] = live[i];
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pend_q   <= '0;
      owner_q  <= '0;
      dvalid_q <= 1'b0;
      ptr_q    <= mst_idx_t'(RESET_PRIO);
    end else begin
      pend_q   <= pend_d;
      owner_q  <= owner_d;
      dvalid_q <= dvalid_d;
      ptr_q    <= ptr_d;
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_ahb_master_arbiter;

  localparam int N  = 3;
  localparam int RP = 0;

  logic                 HCLK = 1'b0;
  logic                 HRESET = 1'b1;
  logic [N-1:0][31:0]   HADDR_M;
  logic [N-1:0][1:0]    HTRANS_M;
  logic [N-1:0]         HWRITE_M;
  logic [N-1:0][2:0]    HSIZE_M;
  logic [N-1:0][31:0]   HWDATA_M;
  logic [N-1:0]         HREADY_M;
  logic [N-1:0]         HRESP_M;
  logic [31:0]          HRDATA_M;
  logic [31:0]          HADDR;
  logic [1:0]           HTRANS;
  logic                 HWRITE;
  logic [2:0]           HSIZE;
  logic [31:0]          HWDATA;
  logic                 HREADY;
  logic                 HRESP;
  logic [31:0]          HRDATA;

  ahb_master_arbiter #(.NUM_MASTERS(N), .RESET_PRIO(RP)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M), .HWRITE_M(HWRITE_M),
    .HSIZE_M(HSIZE_M), .HWDATA_M(HWDATA_M),
    .HREADY_M(HREADY_M), .HRESP_M(HRESP_M), .HRDATA_M(HRDATA_M),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  int n_vec = 0;
  int n_err = 0;

  // Model state: one buffered transfer per master, data-phase owner, pointer.
  bit          m_pv[N];
  logic [31:0] m_pa[N];
  bit          m_pw[N];
  logic [2:0]  m_ps[N];
  int          m_own;
  bit          m_dv;
  int          m_ptr;
  bit          n_pv[N];
  logic [31:0] n_pa[N];
  bit          n_pw[N];
  logic [2:0]  n_ps[N];
  int          n_own;
  bit          n_dv;
  int          n_ptr;

  logic [1:0]  e_htrans;
  logic [31:0] e_haddr, e_hwdata;
  logic        e_hwrite;
  logic [2:0]  e_hsize;
  logic [N-1:0] e_hready_m = '1;
  logic [N-1:0] e_hresp_m;
  int          e_win;

  logic [1:0]  o_htrans;
  logic [31:0] o_haddr, o_hwdata, o_hrdata_m;
  logic        o_hwrite;
  logic [N-1:0] o_hready_m, o_hresp_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit live(input int i);
    return HTRANS_M[i][1];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pv[i] = 0;
    m_own = 0;
    m_dv  = 0;
    m_ptr = RP;
  endtask

  task automatic model_eval();
    if (HRESET) model_reset();
    e_win = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (e_win < 0 && (m_pv[j] || live(j))) e_win = j;
    end
    e_htrans = 2'b00; e_haddr = 0; e_hwrite = 0; e_hsize = 0;
    if (e_win >= 0 && !HRESET) begin
      e_htrans = 2'b10;
      if (m_pv[e_win]) begin
        e_haddr = m_pa[e_win]; e_hwrite = m_pw[e_win]; e_hsize = m_ps[e_win];
      end else begin
        e_haddr = HADDR_M[e_win]; e_hwrite = HWRITE_M[e_win]; e_hsize = HSIZE_M[e_win];
      end
    end
    for (int i = 0; i < N; i++) begin
      bit own;
      own = m_dv && (m_own == i);
      e_hready_m[i] = own ? HREADY : !m_pv[i];
      e_hresp_m[i]  = own && HRESP;
    end
    e_hwdata = m_dv ? HWDATA_M[m_own] : 32'h0;
  endtask

  task automatic model_next();
    bit issue;
    issue = !HRESET && HREADY && (e_win >= 0);
    n_own = m_own; n_dv = m_dv; n_ptr = m_ptr;
    for (int i = 0; i < N; i++) begin
      n_pv[i] = m_pv[i]; n_pa[i] = m_pa[i]; n_pw[i] = m_pw[i]; n_ps[i] = m_ps[i];
      if (issue && e_win == i) n_pv[i] = 0;
      else if (e_hready_m[i] && live(i)) begin
        n_pv[i] = 1; n_pa[i] = HADDR_M[i]; n_pw[i] = HWRITE_M[i]; n_ps[i] = HSIZE_M[i];
      end
    end
    if (issue) begin
      n_own = e_win; n_dv = 1; n_ptr = (e_win + 1) % N;
    end else if (HREADY) n_dv = 0;
    if (HRESET) begin
      for (int i = 0; i < N; i++) n_pv[i] = 0;
      n_own = 0; n_dv = 0; n_ptr = RP;
    end
  endtask

  task automatic tick();
    @(negedge HCLK);
    model_eval();
    chk("htrans",   32'(HTRANS),   32'(e_htrans));
    chk("haddr",    HADDR,         e_haddr);
    chk("hwrite",   32'(HWRITE),   32'(e_hwrite));
    chk("hsize",    32'(HSIZE),    32'(e_hsize));
    chk("hwdata",   HWDATA,        e_hwdata);
    chk("hready_m", 32'(HREADY_M), 32'(e_hready_m));
    chk("hresp_m",  32'(HRESP_M),  32'(e_hresp_m));
    chk("hrdata_m", HRDATA_M,      HRDATA);
    model_next();
    o_htrans = HTRANS; o_haddr = HADDR; o_hwdata = HWDATA; o_hwrite = HWRITE;
    o_hready_m = HREADY_M; o_hresp_m = HRESP_M; o_hrdata_m = HRDATA_M;
    @(posedge HCLK);
    for (int i = 0; i < N; i++) begin
      m_pv[i] = n_pv[i]; m_pa[i] = n_pa[i]; m_pw[i] = n_pw[i]; m_ps[i] = n_ps[i];
    end
    m_own = n_own; m_dv = n_dv; m_ptr = n_ptr;
    #1;
  endtask

  task automatic set_m(input int i, input logic [1:0] tr, input logic [31:0] a, input logic w);
    HTRANS_M[i] = tr; HADDR_M[i] = a; HWRITE_M[i] = w; HSIZE_M[i] = 3'd2;
  endtask

  task automatic all_idle();
    for (int i = 0; i < N; i++) set_m(i, 2'b00, 32'h0, 1'b0);
  endtask

  initial begin
    int err_st;
    err_st = 0;
    HWDATA_M = '0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    all_idle();
    model_reset();

    tick();
    chk("rst_htrans",   32'(o_htrans),   32'h0);
    chk("rst_hready_m", 32'(o_hready_m), 32'h7);
    chk("rst_hresp_m",  32'(o_hresp_m),  32'h0);
    HRESET = 1'b0;

    // M0 write and M1 read arrive together
    set_m(0, 2'b10, 32'h4000_0000, 1'b1);
    set_m(1, 2'b10, 32'h0000_0010, 1'b0);
    tick();
    chk("s2_c1_haddr",  o_haddr,         32'h4000_0000);
    chk("s2_c1_hwrite", 32'(o_hwrite),   32'h1);
    all_idle();
    HWDATA_M[0] = 32'hA5A5_A5A5;
    tick();
    chk("s2_c2_haddr",   o_haddr,           32'h0000_0010);
    chk("s2_c2_hwdata",  o_hwdata,          32'hA5A5_A5A5);
    chk("s2_c2_hready1", 32'(o_hready_m[1]), 32'h0);
    HRDATA = 32'h600D_0010;
    tick();
    chk("s2_c3_hready1", 32'(o_hready_m[1]), 32'h1);
    chk("s2_c3_hrdata",  o_hrdata_m,         32'h600D_0010);
    chk("s2_c3_htrans",  32'(o_htrans),      32'h0);

    // Both masters request continuously: grants alternate starting at M0
    set_m(0, 2'b10, 32'h0000_0100, 1'b0);
    set_m(1, 2'b10, 32'h2000_0100, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("alt_grant", 32'(o_haddr[31:28]), (k % 2 == 1) ? 32'h2 : 32'h0);
    end
    all_idle();
    repeat (3) tick();

    // ERROR on M0's write while M1 is buffered behind it
    set_m(0, 2'b10, 32'h5000_0000, 1'b1);
    tick();
    all_idle();
    HWDATA_M[0] = 32'h1234_5678;
    set_m(1, 2'b10, 32'h0000_0020, 1'b0);
    HREADY = 1'b0; HRESP = 1'b1;
    tick();
    chk("err_c1_hresp0",  32'(o_hresp_m[0]),  32'h1);
    chk("err_c1_hready0", 32'(o_hready_m[0]), 32'h0);
    chk("err_c1_hresp1",  32'(o_hresp_m[1]),  32'h0);
    all_idle();
    HREADY = 1'b1;
    tick();
    chk("err_c2_hresp0",  32'(o_hresp_m[0]),  32'h1);
    chk("err_c2_hready0", 32'(o_hready_m[0]), 32'h1);
    chk("err_c2_haddr",   o_haddr,            32'h0000_0020);
    HRESP = 1'b0; HRDATA = 32'h0BAD_0020;
    tick();
    chk("err_c3_hready1", 32'(o_hready_m[1]), 32'h1);
    chk("err_c3_hresp1",  32'(o_hresp_m[1]),  32'h0);

    // Single master back-to-back reads, no bubble
    set_m(0, 2'b10, 32'h0000_1000, 1'b0);
    tick();
    chk("s1_c1_haddr",   o_haddr,            32'h0000_1000);
    set_m(0, 2'b10, 32'h0000_1004, 1'b0);
    HRDATA = 32'hD000_1000;
    tick();
    chk("s1_c2_htrans",  32'(o_htrans),      32'h2);
    chk("s1_c2_haddr",   o_haddr,            32'h0000_1004);
    chk("s1_c2_hrdata",  o_hrdata_m,         32'hD000_1000);
    chk("s1_c2_hready1", 32'(o_hready_m[1]), 32'h1);
    all_idle();
    HRDATA = 32'hD000_1004;
    tick();
    chk("s1_c3_hrdata",  o_hrdata_m,         32'hD000_1004);

    // Reset while M0 is in flight and M1 is buffered
    set_m(0, 2'b10, 32'h0000_3000, 1'b1);
    tick();
    all_idle();
    set_m(1, 2'b10, 32'h0000_3100, 1'b0);
    HREADY = 1'b0;
    tick();
    set_m(0, 2'b10, 32'h0000_3000, 1'b1);
    HRESET = 1'b1;
    tick();
    chk("rst_mid_htrans",   32'(o_htrans),   32'h0);
    chk("rst_mid_hready_m", 32'(o_hready_m), 32'h7);
    HRESET = 1'b0; HREADY = 1'b1;
    tick();
    chk("rst_first_grant",  o_haddr,         32'h0000_3000);

    // Randomized traffic; masters hold their transfer until HREADY_M accepts it
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (e_hready_m[i]) begin
          int r;
          r = $urandom_range(0, 9);
          HTRANS_M[i] = (r < 5) ? 2'b10 : (r == 5) ? 2'b01 : (r == 6) ? 2'b11 : 2'b00;
          HADDR_M[i]  = $urandom & 32'hFFFF_FFFC;
          HWRITE_M[i] = 1'($urandom_range(0, 1));
          HSIZE_M[i]  = 3'($urandom_range(0, 2));
          HWDATA_M[i] = $urandom;
        end
      end
      if (err_st == 1) begin
        HREADY = 1'b1; HRESP = 1'b1; err_st = 0;
      end else if (m_dv && $urandom_range(0, 19) == 0) begin
        HREADY = 1'b0; HRESP = 1'b1; err_st = 1;
      end else begin
        HREADY = !m_dv || ($urandom_range(0, 3) != 0); HRESP = 1'b0;
      end
      HRDATA = $urandom;
      HRESET = ($urandom_range(0, 399) == 0);
      if (HRESET) err_st = 0;
      tick();
    end
    HRESET = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
